// File: rtl/dpram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dpram_rr_arbiter
// Brief   : Round-robin sharing of both DpRam ports among N requesters, with
//           registered response steering back to the issuing requester.
// Revision: 1.0 - initial release
// ============================================================================
module dpram_rr_arbiter #(
  parameter  int N     = 4,
  parameter  int DW    = 8,
  parameter  int WORDS = 256,
  localparam int AW    = $clog2(WORDS),
  localparam int PW    = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N-1:0]    req_wr,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*DW-1:0] req_wdata,
  output logic [N-1:0]    rsp_valid,
  output logic [N*DW-1:0] rsp_rdata,
  output logic [AW-1:0]   ram_addr_a,
  output logic [AW-1:0]   ram_addr_b,
  output logic            ram_wr_a,
  output logic            ram_wr_b,
  output logic [DW-1:0]   ram_din_a,
  output logic [DW-1:0]   ram_din_b,
  input  logic [DW-1:0]   ram_qout_a,
  input  logic [DW-1:0]   ram_qout_b
);

  logic [PW-1:0] r_ptr;
  logic          r_rsp_vld_a;
  logic          r_rsp_vld_b;
  logic [PW-1:0] r_rsp_idx_a;
  logic [PW-1:0] r_rsp_idx_b;

  logic          w_gnt_a;
  logic          w_gnt_b;
  logic [PW-1:0] w_idx_a;
  logic [PW-1:0] w_idx_b;
  logic [PW-1:0] w_cand;
  logic [PW-1:0] w_ptr_nxt;

  // Scan from ptr; first valid takes A, the next non-conflicting valid takes B.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    w_idx_a = '0;
    w_idx_b = '0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = PW'((int'(r_ptr) + k) % N);
      if (req_valid[w_cand]) begin
        if (!w_gnt_a) begin
          w_gnt_a = 1'b1;
          w_idx_a = w_cand;
        end else if (!w_gnt_b &&
                     !((req_addr[w_cand*AW +: AW] == req_addr[w_idx_a*AW +: AW]) &&
                       (req_wr[w_cand] || req_wr[w_idx_a]))) begin
          w_gnt_b = 1'b1;
          w_idx_b = w_cand;
        end
      end
    end
  end

  // B always follows A in rotation, so it is the furthest grant when present.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_gnt_b) begin
      w_ptr_nxt = (w_idx_b == PW'(N-1)) ? '0 : w_idx_b + 1'b1;
    end else if (w_gnt_a) begin
      w_ptr_nxt = (w_idx_a == PW'(N-1)) ? '0 : w_idx_a + 1'b1;
    end
  end

  assign ram_addr_a = w_gnt_a ? req_addr[w_idx_a*AW +: AW]  : '0;
  assign ram_wr_a   = w_gnt_a ? req_wr[w_idx_a]             : 1'b0;
  assign ram_din_a  = w_gnt_a ? req_wdata[w_idx_a*DW +: DW] : '0;
  assign ram_addr_b = w_gnt_b ? req_addr[w_idx_b*AW +: AW]  : '0;
  assign ram_wr_b   = w_gnt_b ? req_wr[w_idx_b]             : 1'b0;
  assign ram_din_b  = w_gnt_b ? req_wdata[w_idx_b*DW +: DW] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_rsp_vld_a <= 1'b0;
      r_rsp_vld_b <= 1'b0;
      r_rsp_idx_a <= '0;
      r_rsp_idx_b <= '0;
    end else begin
      r_ptr       <= w_ptr_nxt;
      r_rsp_vld_a <= w_gnt_a;
      r_rsp_vld_b <= w_gnt_b;
      r_rsp_idx_a <= w_idx_a;
      r_rsp_idx_b <= w_idx_b;
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_req
      logic w_own_a;
      logic w_own_b;

      assign w_own_a = r_rsp_vld_a && (r_rsp_idx_a == PW'(gi));
      assign w_own_b = r_rsp_vld_b && (r_rsp_idx_b == PW'(gi));

      assign req_ready[gi] = (w_gnt_a && (w_idx_a == PW'(gi))) ||
                             (w_gnt_b && (w_idx_b == PW'(gi)));
      assign rsp_valid[gi] = w_own_a || w_own_b;
      assign rsp_rdata[gi*DW +: DW] = w_own_a ? ram_qout_a :
                                      (w_own_b ? ram_qout_b : '0);
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dpram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dpram_rr_arbiter
// Brief   : Directed bench for dpram_rr_arbiter with a behavioural DpRam and
//           a response scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dpram_rr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int WORDS = 256;
  localparam int AW    = $clog2(WORDS);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_wr;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    rsp_valid;
  logic [N*DW-1:0] rsp_rdata;
  logic [AW-1:0]   ram_addr_a;
  logic [AW-1:0]   ram_addr_b;
  logic            ram_wr_a;
  logic            ram_wr_b;
  logic [DW-1:0]   ram_din_a;
  logic [DW-1:0]   ram_din_b;
  logic [DW-1:0]   ram_qout_a = '0;
  logic [DW-1:0]   ram_qout_b = '0;

  dpram_rr_arbiter #(.N(N), .DW(DW), .WORDS(WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .ram_addr_a (ram_addr_a),
    .ram_addr_b (ram_addr_b),
    .ram_wr_a   (ram_wr_a),
    .ram_wr_b   (ram_wr_b),
    .ram_din_a  (ram_din_a),
    .ram_din_b  (ram_din_b),
    .ram_qout_a (ram_qout_a),
    .ram_qout_b (ram_qout_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pat(input int a);
    return (a == 'h10) ? 8'h5A : (DW'(a) ^ 8'hC3);
  endfunction

  // Behavioural DpRam: registered read, write-through on qout.
  logic          ram_init;
  logic [DW-1:0] mem [WORDS];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int a = 0; a < WORDS; a++) mem[a] <= pat(a);
    end else begin
      if (ram_wr_a) mem[ram_addr_a] <= ram_din_a;
      if (ram_wr_b) mem[ram_addr_b] <= ram_din_b;
    end
    ram_qout_a <= ram_wr_a ? ram_din_a : mem[ram_addr_a];
    ram_qout_b <= ram_wr_b ? ram_din_b : mem[ram_addr_b];
  end

  typedef struct {
    int            cyc;
    int            idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ref_mem [WORDS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Responses due this cycle are popped and compared against the DUT.
  logic [N-1:0]    mon_mask;
  logic [N*DW-1:0] mon_data;
  always @(negedge clk) begin
    mon_mask = '0;
    mon_data = '0;
    for (int j = sb.size() - 1; j >= 0; j--) begin
      if (sb[j].cyc == cyc) begin
        mon_mask[sb[j].idx]            = 1'b1;
        mon_data[sb[j].idx*DW +: DW]   = sb[j].data;
        sb.delete(j);
      end
    end
    chk($sformatf("rsp_valid@%0d", cyc), 64'(rsp_valid), 64'(mon_mask));
    for (int i = 0; i < N; i++) begin
      if (mon_mask[i])
        chk($sformatf("rsp_rdata[%0d]@%0d", i, cyc), 64'(rsp_rdata[i*DW +: DW]),
            64'(mon_data[i*DW +: DW]));
    end
  end

  task automatic step(input string tag, input logic [N-1:0] v, input logic [N-1:0] wr,
                      input logic [N*AW-1:0] a, input logic [N*DW-1:0] wd,
                      input logic [N-1:0] exp_rdy);
    req_valid = v;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = wd;
    @(negedge clk);
    chk({tag, " req_ready"}, 64'(req_ready), 64'(exp_rdy));
    for (int i = 0; i < N; i++) begin
      if (exp_rdy[i]) begin
        logic [AW-1:0] ad;
        ad = a[i*AW +: AW];
        if (wr[i]) begin
          ref_mem[ad] = wd[i*DW +: DW];
          sb.push_back('{cyc + 1, i, wd[i*DW +: DW]});
        end else begin
          sb.push_back('{cyc + 1, i, ref_mem[ad]});
        end
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < WORDS; a++) ref_mem[a] = pat(a);
    rst_n     = 1'b0;
    ram_init  = 1'b1;
    req_valid = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    #2;
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("reset ram", 64'({ram_addr_a, ram_addr_b, ram_wr_a, ram_wr_b, ram_din_a, ram_din_b}), 64'd0);
    tick;
    tick;
    ram_init = 1'b0;
    tick;
    rst_n = 1'b1;

    step("rd2", 4'b0100, 4'b0000, 32'h00_10_00_00, '0, 4'b0100); tick;
    step("rd3", 4'b1000, 4'b0000, 32'h11_00_00_00, '0, 4'b1000); tick;

    step("full0", 4'b1111, 4'b0000, 32'h04_03_02_01, '0, 4'b0011); tick;
    step("full1", 4'b1111, 4'b0000, 32'h04_03_02_01, '0, 4'b1100); tick;
    step("full2", 4'b1111, 4'b0000, 32'h04_03_02_01, '0, 4'b0011); tick;
    step("idle",  4'b0000, 4'b0000, '0, '0, 4'b0000); tick;

    step("ww0", 4'b0011, 4'b0011, 32'h00_00_20_20, 32'h00_00_BB_AA, 4'b0001);
    chk("ww0 ram drive", 64'({ram_addr_a, ram_wr_a, ram_din_a, ram_addr_b, ram_wr_b, ram_din_b}),
        64'({8'h20, 1'b1, 8'hAA, 8'h00, 1'b0, 8'h00}));
    tick;
    step("ww1",  4'b0010, 4'b0010, 32'h00_00_20_20, 32'h00_00_BB_AA, 4'b0010); tick;
    step("rd20", 4'b1000, 4'b0000, 32'h20_00_00_00, '0, 4'b1000); tick;

    step("rw0", 4'b0111, 4'b0001, 32'h00_41_40_40, 32'h00_00_00_33, 4'b0101); tick;
    step("rw1", 4'b0010, 4'b0000, 32'h00_00_40_00, '0, 4'b0010); tick;

    step("same", 4'b1010, 4'b0000, 32'h07_00_07_00, '0, 4'b1010); tick;

    step("single", 4'b0001, 4'b0000, 32'h00_00_00_05, '0, 4'b0001);
    chk("single ram drive", 64'({ram_addr_a, ram_wr_a, ram_addr_b, ram_wr_b, ram_din_b}),
        64'({8'h05, 1'b0, 8'h00, 1'b0, 8'h00}));
    tick;

    step("rst_rd", 4'b0100, 4'b0000, 32'h00_08_00_00, '0, 4'b0100); tick;
    chk("pre-reset rsp_valid", 64'(rsp_valid), 64'(4'b0100));
    req_valid = '0;
    rst_n     = 1'b0;
    sb.delete();
    #1;
    chk("mid-reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid-reset rsp_rdata", 64'(rsp_rdata), 64'd0);
    tick;
    rst_n = 1'b1;

    step("post_rst0", 4'b1100, 4'b1100, 32'h50_50_00_00, 32'h99_77_00_00, 4'b0100); tick;
    step("post_rst1", 4'b1000, 4'b1000, 32'h50_50_00_00, 32'h99_77_00_00, 4'b1000); tick;
    step("rd50",  4'b0001, 4'b0000, 32'h00_00_00_50, '0, 4'b0001); tick;
    step("drain", 4'b0000, 4'b0000, '0, '0, 4'b0000); tick;

    chk("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dpram_rr_arbiter.md
Name: dpram_rr_arbiter

Overview:
- Shares both ports of the team's dual-port RAM (DpRam, DW/WORDS parameterised) between N requesters.
- Each cycle, round-robin arbitration grants up to two non-conflicting requests: one on port A, one on port B.
- Routes each registered RAM read result back to the requester that issued it.
- Sits between client engines (DMA, packet buffers) and one DpRam instance.
- DpRam behaviour relied on:
  - qout returns one cycle after the address is presented.
  - On a write, qout returns the write data.

Parameters:
- N, 4: number of requesters, minimum 2.
- DW, 8: data width, matches DpRam DW.
- WORDS, 256: RAM depth, matches DpRam WORDS.
- AW (localparam): $clog2(WORDS).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N  per-requester request valid.
- req_ready  out  N  grant; transfer occurs when valid && ready.
- req_wr  in  N  1 = write, 0 = read.
- req_addr  in  N*AW  packed; requester i uses bits [i*AW +: AW].
- req_wdata  in  N*DW  packed write data.
- rsp_valid  out  N  one-cycle pulse carrying the result of an accepted request.
- rsp_rdata  out  N*DW  packed response data; valid only where rsp_valid is set.
- ram_addr_a / ram_addr_b  out  AW  to DpRam addr_a / addr_b.
- ram_wr_a / ram_wr_b  out  1  to DpRam wr_a / wr_b.
- ram_din_a / ram_din_b  out  DW  to DpRam din_a / din_b.
- ram_qout_a / ram_qout_b  in  DW  from DpRam qout_a / qout_b.

Behaviour:
- State:
  - ptr: round-robin pointer, $clog2(N) bits, reset 0.
  - rsp_valid_a / rsp_valid_b: response-pending flags, reset 0.
  - rsp_idx_a / rsp_idx_b: owner index of each pending response, reset 0.
- Arbitration is combinational, evaluated every cycle:
  - Port A: first requester with req_valid set, scanning ptr, ptr+1, ..., ptr+N-1 mod N.
  - Port B: next valid requester after A in the same rotation that does not conflict with A.
  - Conflict: equal address AND at least one of the two is a write.
  - A request is never split across ports; each requester gets at most one grant per cycle.
  - If no candidate exists for a port, that port is idle.
- req_ready[i] = 1 iff requester i is granted on A or B.
  - It depends combinationally on req_valid/req_wr/req_addr.
  - Requesters must not derive req_valid from req_ready.
  - A request must stay stable while valid && !ready.
- RAM drive, combinational from the grant:
  - Granted port: addr, wr, din taken from the granted requester.
  - Idle port: addr = 0, wr = 0, din = 0.
- Pointer update at clk:
  - If any grant: ptr <= (highest-rotation granted index + 1) mod N, i.e. B's index if B is granted, else A's.
  - If no grant: ptr holds.
- Response path, registered:
  - At the clk after a grant, set rsp_valid_x = 1 and rsp_idx_x = owner; otherwise clear rsp_valid_x.
  - Latency: request accepted in cycle T produces rsp_valid[i] in cycle T+1.
  - rsp_rdata for i = ram_qout_a if A's response belongs to i, else ram_qout_b. A and B never share an owner.
  - Writes also respond; rsp_rdata then equals the written data.
- Output reset values:
  - req_ready 0, since no valids are asserted in reset.
  - rsp_valid 0 and rsp_rdata 0.
  - All ram_* outputs 0.
- Throughput: two accesses per cycle when non-conflicting; no bubbles between back-to-back grants.
- Boundary cases:
  - All N valid: two grants per cycle. Every requester is served within ceil(N/2) cycles of raising valid, assuming no conflicts.
  - Conflicting pair, same address with a write: the second requester in rotation waits. After the ptr update it is first in rotation next cycle, so it cannot starve.
  - Two reads to the same address: both granted.
  - Single requester valid: granted on port A only; port B idle.
  - Reset asserted mid-operation: pending responses are dropped and rsp_valid goes to 0 immediately (asynchronous). RAM contents are not affected by this block.

Test Plan:
- Reset: with rst_n = 0, all outputs are 0. Release reset, then requester 2 reads address 0x10 (RAM preloaded with 0x5A) -> req_ready = 0b0100 in the same cycle; next cycle rsp_valid = 0b0100 and rsp_rdata[2] = 0x5A.
- Full contention: N = 4, all valid reads to distinct addresses, ptr = 0 -> cycle 0 grants {0,1}, cycle 1 grants {2,3}, cycle 2 grants {0,1}. rsp_valid follows one cycle behind each grant.
- Write/write conflict: requesters 0 and 1 write 0xAA and 0xBB to address 0x20 -> cycle 0 grants only requester 0; cycle 1 grants requester 1. A later read of 0x20 returns 0xBB.
- Read/write conflict: requester 0 writes 0x33 to 0x40 while requester 1 reads 0x40 -> requester 1 is deferred one cycle and then reads 0x33. Requester 2's read of 0x41 in the same cycle is granted on port B.
- Same-address reads: requesters 1 and 3 both read 0x07 -> both granted in one cycle, and both rsp_rdata equal the RAM content.
- Reset mid-flight: assert rst_n = 0 in the cycle after a grant -> rsp_valid is 0 immediately, no response is delivered, and ptr = 0 after release.
